// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET return sequencer at the M stage.
// Picks one event per cycle, drives CP0 write strobes, flushes, then redirects fetch.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [4:0]  INT_CODE     = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_exc,
    input  logic [4:0]  m_exccode,
    input  logic        m_eret,
    input  logic        int_req,
    input  logic [29:0] cp0_epc,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        epc_we,
    output logic [29:0] epc_val,
    output logic [4:0]  exccode,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTER = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_VEC   = 3'd3;
    localparam logic [2:0] S_RET   = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;

    // A delay-slot instruction restarts at its branch, one word earlier (wraps mod 2^32).
    function automatic logic [29:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] adj;
        adj = bd ? (pc - 32'd4) : pc;
        return adj[31:2];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (m_valid) begin
                    if (int_req) begin
                        state_d = S_ENTER;
                        code_d  = INT_CODE;
                        pc_d    = m_pc;
                        bd_d    = m_bd;
                    end else if (m_exc) begin
                        state_d = S_ENTER;
                        code_d  = m_exccode;
                        pc_d    = m_pc;
                        bd_d    = m_bd;
                    end else if (m_eret) begin
                        state_d = S_RET;
                    end
                end
            end
            S_ENTER: begin
                cnt_d   = CNT_INIT;
                state_d = (FLUSH_CYCLES <= 1) ? S_VEC : S_FLUSH;
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_VEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        bd_q   <= bd_d;
        code_q <= code_d;
    end

    // Outputs are pure state decodes; data fields are zeroed outside their strobe.
    assign exl_set     = (state_q == S_ENTER);
    assign epc_we      = (state_q == S_ENTER);
    assign epc_val     = epc_we ? epc_of(pc_q, bd_q) : 30'd0;
    assign exccode     = epc_we ? code_q : 5'd0;
    assign exl_clr     = (state_q == S_RET);
    assign flush       = (state_q == S_ENTER) || (state_q == S_FLUSH) || (state_q == S_RET);
    assign redirect    = (state_q == S_VEC) || (state_q == S_RET);
    assign redirect_pc = (state_q == S_VEC) ? HANDLER_ADDR :
                         (state_q == S_RET) ? {cp0_epc, 2'b00} : 32'd0;
    assign busy        = (state_q != S_IDLE);

endmodule
